// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit.
//
// Owns the architectural HI/LO registers. A mult/multu/div/divu in E
// computes its full 64-bit result immediately into a pending buffer, then
// holds busy for a fixed number of cycles before committing the buffer to
// HI/LO. This models a multi-cycle unit with a deterministic latency.
// mthi/mtlo write HI/LO directly when the unit is idle. mfhi/mflo read
// through md_rd.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset; discards any in-flight result
//   md_op       E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//               5 mthi, 6 mtlo, 7 reserved (none)
//   rs_val      forwarded rs operand (dividend / multiplicand / mt source)
//   rt_val      forwarded rt operand (divisor / multiplier)
//   flush       exception this cycle: blocks a new start or mt write
//   md_rd_sel   read select, 0 = HI, 1 = LO
//   md_instr_D  the D-stage instruction uses the MD unit
//   busy        operation in flight
//   hi, lo      architectural HI/LO
//   md_rd       HI or LO per md_rd_sel (combinational)
//   stall_md    stall request to the hazard unit (combinational)
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        md_rd_sel,
  input  logic        md_instr_D,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rd,
  output logic        stall_md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  // Result packing for all arithmetic helpers: {hi, lo}.
  function automatic logic [63:0] mul_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic signed [63:0] ax;
    logic signed [63:0] bx;
    ax = {{32{a[31]}}, a};
    bx = {{32{b[31]}}, b};
    mul_signed = ax * bx;
  endfunction

  function automatic logic [63:0] mul_unsigned(input logic [31:0] a,
                                               input logic [31:0] b);
    mul_unsigned = {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                               input logic [31:0] b);
    if (b == 32'd0) div_unsigned = '0;
    else            div_unsigned = {a % b, a / b};
  endfunction

  // Sign-magnitude division: quotient truncates toward zero, remainder takes
  // the dividend's sign. 0x80000000 / -1 falls out naturally as quotient
  // 0x80000000 (its magnitude negates to itself), remainder 0.
  function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    ma = a;
    mb = b;
    if (a[31]) ma = -ma;
    if (b[31]) mb = -mb;
    if (mb == 32'd0) begin
      q = '0;
      r = '0;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (a[31] ^ b[31]) q = -q;
    if (a[31])         r = -r;
    div_signed = {r, q};
  endfunction

  md_op_e           op_p0;
  logic             is_mul_p0;
  logic             is_div_p0;
  logic             is_md_p0;
  logic             start_p0;
  logic             mthi_p0;
  logic             mtlo_p0;
  logic             div_zero_p0;
  logic [63:0]      res_p0;

  logic [31:0]      pend_hi_p1;
  logic [31:0]      pend_lo_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] cnt_p1;

  // Stage p0: decode and compute the full result from the E operands.
  assign op_p0       = md_op_e'(md_op);
  assign is_mul_p0   = (op_p0 == OP_MULT) || (op_p0 == OP_MULTU);
  assign is_div_p0   = (op_p0 == OP_DIV)  || (op_p0 == OP_DIVU);
  assign is_md_p0    = is_mul_p0 || is_div_p0;
  assign start_p0    = is_md_p0 && !busy && !flush;
  assign mthi_p0     = (op_p0 == OP_MTHI) && !busy && !flush;
  assign mtlo_p0     = (op_p0 == OP_MTLO) && !busy && !flush;
  assign div_zero_p0 = is_div_p0 && (rt_val == 32'd0);

  always_comb begin
    res_p0 = '0;
    case (op_p0)
      OP_MULT:  res_p0 = mul_signed(rs_val, rt_val);
      OP_MULTU: res_p0 = mul_unsigned(rs_val, rt_val);
      OP_DIV:   res_p0 = div_signed(rs_val, rt_val);
      OP_DIVU:  res_p0 = div_unsigned(rs_val, rt_val);
      default:  res_p0 = '0;
    endcase
  end

  // Stage p1: pending result held while the countdown runs, then committed.
  // vld_p1 marks whether the pending result may be committed (divide by
  // zero still occupies the unit but leaves HI/LO untouched).
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      cnt_p1     <= '0;
      vld_p1     <= 1'b0;
      pend_hi_p1 <= '0;
      pend_lo_p1 <= '0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      if (start_p0) begin
        pend_hi_p1 <= res_p0[63:32];
        pend_lo_p1 <= res_p0[31:0];
        vld_p1     <= !div_zero_p0;
        cnt_p1     <= is_mul_p0 ? MULT_LOAD : DIV_LOAD;
        busy       <= 1'b1;
      end else if (busy) begin
        if (cnt_p1 == CNT_ONE) begin
          busy   <= 1'b0;
          cnt_p1 <= '0;
          if (vld_p1) begin
            hi <= pend_hi_p1;
            lo <= pend_lo_p1;
          end
        end else begin
          cnt_p1 <= cnt_p1 - CNT_ONE;
        end
      end
      // mt writes require !busy, so they never collide with a commit.
      if (mthi_p0) hi <= rs_val;
      if (mtlo_p0) lo <= rs_val;
    end
  end

  assign md_rd    = md_rd_sel ? lo : hi;
  // The start cycle itself stalls too, since busy has not yet risen.
  assign stall_md = md_instr_D && (busy || (is_md_p0 && !flush));

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit.
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too, away from the active edge. A reference model computes HI/LO results
// with plain integer arithmetic and tracks the architectural HI/LO.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        md_rd_sel;
  logic        md_instr_D;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_rd;
  logic        stall_md;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .md_rd_sel(md_rd_sel), .md_instr_D(md_instr_D),
    .busy(busy), .hi(hi), .lo(lo), .md_rd(md_rd), .stall_md(stall_md)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // The hazard unit must never present a new MD op while busy.
  always @(negedge clk) begin
    if (!reset && busy === 1'b1 && md_op >= 3'd1 && md_op <= 3'd4) begin
      errors++;
      $display("FAIL guard: md_op=%0d presented while busy", md_op);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: returns {hi,lo} and whether HI/LO are written.
  function automatic void ref_result(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] rh,
                                     output logic [31:0] rl, output bit wr);
    longint sp;
    longint unsigned up;
    int sa, sb;
    rh = m_hi; rl = m_lo; wr = 1'b1;
    case (op)
      3'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        rh = sp[63:32]; rl = sp[31:0];
      end
      3'd2: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        rh = up[63:32]; rl = up[31:0];
      end
      3'd3: begin
        if (b == 0) wr = 1'b0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000; rh = 32'h0;
        end else begin
          sa = a; sb = b;
          rl = sa / sb; rh = sa % sb;
        end
      end
      3'd4: begin
        if (b == 0) wr = 1'b0;
        else begin rl = a / b; rh = a % b; end
      end
      default: wr = 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; md_op = 3'd0; rs_val = 32'h0; rt_val = 32'h0;
    flush = 1'b0; md_rd_sel = 1'b0; md_instr_D = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || stall_md !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b hi=%h lo=%h stall=%b, want 0/0/0/0", busy, hi, lo, stall_md);
    end
    m_hi = 32'h0; m_lo = 32'h0;
  endtask

  task automatic test_mt();
    md_op = 3'd5; rs_val = 32'h0000_0011; tick();
    md_op = 3'd6; rs_val = 32'h0000_0022; tick();
    md_op = 3'd0;
    m_hi = 32'h11; m_lo = 32'h22;
    checks++;
    if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
      errors++;
      $display("FAIL mt: hi=%h lo=%h busy=%b, want %h %h 0", hi, lo, busy, m_hi, m_lo);
    end
    md_rd_sel = 1'b0; #1;
    checks++;
    if (md_rd !== m_hi) begin errors++; $display("FAIL md_rd_hi: got %h want %h", md_rd, m_hi); end
    md_rd_sel = 1'b1; #1;
    checks++;
    if (md_rd !== m_lo) begin errors++; $display("FAIL md_rd_lo: got %h want %h", md_rd, m_lo); end
  endtask

  task automatic test_arith();
    logic [2:0]  ops [5] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd3};
    logic [31:0] rsv [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] rtv [5] = '{32'd7, 32'd7, 32'd7, 32'd2, 32'hFFFF_FFFF};
    logic [31:0] ehi [5] = '{32'hFFFF_FFFF, 32'd6, 32'd2, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] elo [5] = '{32'hFFFF_FFEB, 32'hFFFF_FFEB, 32'd14, 32'hFFFF_FFFD, 32'h8000_0000};
    for (int k = 0; k < 5; k++) begin
      int n;
      n = (ops[k] <= 3'd2) ? MC : DC;
      md_op = ops[k]; rs_val = rsv[k]; rt_val = rtv[k];
      tick();
      md_op = 3'd0;
      for (int i = 0; i < n; i++) begin
        checks++;
        if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
          errors++;
          $display("FAIL arith%0d_busy c%0d: busy=%b hi=%h lo=%h, want 1 %h %h", k, i, busy, hi, lo, m_hi, m_lo);
        end
        tick();
      end
      m_hi = ehi[k]; m_lo = elo[k];
      checks++;
      if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL arith%0d_done: busy=%b hi=%h lo=%h, want 0 %h %h", k, busy, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_div_zero();
    md_op = 3'd5; rs_val = 32'h11; tick();
    md_op = 3'd6; rs_val = 32'h22; tick();
    m_hi = 32'h11; m_lo = 32'h22;
    md_op = 3'd3; rs_val = 32'h1234; rt_val = 32'h0; tick();
    md_op = 3'd0;
    for (int i = 0; i < DC; i++) begin
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL divzero_busy c%0d: busy=%b want 1", i, busy); end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL divzero_done: busy=%b hi=%h lo=%h, want 0 %h %h", busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_flush();
    md_op = 3'd1; rs_val = 32'h3; rt_val = 32'h5; flush = 1'b1; tick();
    md_op = 3'd0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_mult: busy=%b want 0", busy); end
    for (int i = 0; i < MC + 1; i++) tick();
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++; $display("FAIL flush_mult_hilo: hi=%h lo=%h want %h %h", hi, lo, m_hi, m_lo);
    end
    md_op = 3'd5; rs_val = 32'hDEAD_BEEF; flush = 1'b1; tick();
    md_op = 3'd0; flush = 1'b0;
    checks++;
    if (hi !== m_hi) begin errors++; $display("FAIL flush_mthi: hi=%h want %h", hi, m_hi); end
    md_op = 3'd4; rs_val = 32'd100; rt_val = 32'd7; tick();
    md_op = 3'd0;
    for (int i = 0; i < DC; i++) begin
      flush = (i >= 2 && i <= 6);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL flush_div_busy c%0d: busy=%b want 1", i, busy); end
      tick();
    end
    flush = 1'b0;
    m_hi = 32'd2; m_lo = 32'd14;
    checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL flush_div_done: busy=%b hi=%h lo=%h, want 0 %h %h", busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_stall();
    md_instr_D = 1'b1; md_op = 3'd1; rs_val = 32'd3; rt_val = 32'd4; #1;
    checks++;
    if (stall_md !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_start: stall=%b busy=%b want 1 0", stall_md, busy);
    end
    tick();
    md_op = 3'd0;
    for (int i = 0; i < MC; i++) begin
      checks++;
      if (stall_md !== 1'b1) begin errors++; $display("FAIL stall_busy c%0d: stall=%b want 1", i, stall_md); end
      tick();
    end
    m_hi = 32'd0; m_lo = 32'd12;
    checks++;
    if (stall_md !== 1'b0 || lo !== m_lo || hi !== m_hi) begin
      errors++; $display("FAIL stall_end: stall=%b hi=%h lo=%h want 0 %h %h", stall_md, hi, lo, m_hi, m_lo);
    end
    md_op = 3'd1; flush = 1'b1; #1;
    checks++;
    if (stall_md !== 1'b0) begin errors++; $display("FAIL stall_flush: stall=%b want 0", stall_md); end
    tick();
    flush = 1'b0; md_instr_D = 1'b0; #1;
    checks++;
    if (stall_md !== 1'b0) begin errors++; $display("FAIL nostall_start: stall=%b want 0", stall_md); end
    tick();
    md_op = 3'd0;
    for (int i = 0; i < MC; i++) begin
      checks++;
      if (stall_md !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL nostall_busy c%0d: stall=%b busy=%b want 0 1", i, stall_md, busy);
      end
      tick();
    end
  endtask

  task automatic test_reset_midop();
    md_op = 3'd1; rs_val = 32'd5; rt_val = 32'd6; tick();
    md_op = 3'd0;
    tick(); tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL reset_midop: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
        errors++; $display("FAIL reset_late c%0d: busy=%b hi=%h lo=%h want 0 0 0", i, busy, hi, lo);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [2:0]  op;
      logic [31:0] a, b, rh, rl;
      logic        fl, idd;
      bit          wr;
      int          n;
      op = 3'($urandom_range(1, 6));
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      fl  = ($urandom_range(0, 4) == 0);
      idd = 1'($urandom_range(0, 1));
      md_op = op; rs_val = a; rt_val = b; flush = fl; md_instr_D = idd; #1;
      checks++;
      if (stall_md !== (idd && op <= 3'd4 && !fl)) begin
        errors++; $display("FAIL rnd%0d_stall_start: stall=%b op=%0d fl=%b id=%b", k, stall_md, op, fl, idd);
      end
      ref_result(op, a, b, rh, rl, wr);
      n = 0;
      if (!fl) begin
        if (op == 3'd5) m_hi = a;
        else if (op == 3'd6) m_lo = a;
        else n = (op <= 3'd2) ? MC : DC;
      end
      tick();
      md_op = 3'd0;
      for (int i = 0; i < n; i++) begin
        flush = ($urandom_range(0, 3) == 0);
        checks++;
        if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo || stall_md !== idd) begin
          errors++;
          $display("FAIL rnd%0d_busy c%0d: busy=%b hi=%h lo=%h stall=%b want 1 %h %h %b",
                   k, i, busy, hi, lo, stall_md, m_hi, m_lo, idd);
        end
        tick();
      end
      flush = 1'b0;
      if (n > 0 && wr) begin m_hi = rh; m_lo = rl; end
      md_rd_sel = 1'($urandom_range(0, 1)); #1;
      checks++;
      if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo || md_rd !== (md_rd_sel ? m_lo : m_hi)) begin
        errors++;
        $display("FAIL rnd%0d_done op=%0d a=%h b=%h: busy=%b hi=%h lo=%h rd=%h want 0 %h %h",
                 k, op, a, b, busy, hi, lo, md_rd, m_hi, m_lo);
      end
    end
    md_instr_D = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mt();
    test_arith();
    test_div_zero();
    test_flush();
    test_stall();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
